// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared codes for the MIPS ALU control / MULTU-DIVU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALUOp codes from Control
    localparam logic [2:0] c_aluop_and   = 3'b000;
    localparam logic [2:0] c_aluop_or    = 3'b001;
    localparam logic [2:0] c_aluop_add   = 3'b010;
    localparam logic [2:0] c_aluop_sub   = 3'b011;
    localparam logic [2:0] c_aluop_funct = 3'b100;

    // ALU control codes
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // R-type funct codes
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_divu  = 6'b011011;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;

    // Write-back mux select
    localparam logic [1:0] c_mf_alu = 2'b00;
    localparam logic [1:0] c_mf_hi  = 2'b01;
    localparam logic [1:0] c_mf_lo  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Combinational ALUOp/funct decode. DIVU is recognised only
//               when DIV_EN is defined; otherwise it decodes as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       illegal,
    output logic [1:0] mf_sel,
    output logic       is_mul,
    output logic       is_div
);

    always_comb begin
        alu_ctrl = c_alu_add;
        illegal  = 1'b0;
        mf_sel   = c_mf_alu;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        case (aluop)
            c_aluop_and: alu_ctrl = c_alu_and;
            c_aluop_or:  alu_ctrl = c_alu_or;
            c_aluop_add: alu_ctrl = c_alu_add;
            c_aluop_sub: alu_ctrl = c_alu_sub;
            c_aluop_funct: begin
                case (funct)
                    c_fn_add:   alu_ctrl = c_alu_add;
                    c_fn_sub:   alu_ctrl = c_alu_sub;
                    c_fn_and:   alu_ctrl = c_alu_and;
                    c_fn_or:    alu_ctrl = c_alu_or;
                    c_fn_slt:   alu_ctrl = c_alu_slt;
                    c_fn_multu: is_mul   = 1'b1;
                    c_fn_divu: begin
`ifdef DIV_EN
                        is_div  = 1'b1;
`else
                        illegal = 1'b1;
`endif
                    end
                    c_fn_mfhi:  mf_sel   = c_mf_hi;
                    c_fn_mflo:  mf_sel   = c_mf_lo;
                    default:    illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : ALU control decode plus radix-2 MULTU/DIVU sequencer with
//               HI/LO registers. Define DIV_EN to build the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       aluop,
    input  logic [5:0]       funct,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [2:0]       alu_ctrl,
    output logic             illegal,
    output logic             stall,
    output logic [1:0]       mf_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_done,
    output logic             div0
);

    localparam int              CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_md_funct;
    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    alu_ctrl_decode u_decode (
        .aluop    (aluop),
        .funct    (funct),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal),
        .mf_sel   (mf_sel),
        .is_mul   (w_is_mul),
        .is_div   (w_is_div)
    );

    assign md_busy    = (r_state == ST_RUN);
    assign md_done    = (r_state == ST_DONE);
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign w_md_funct = (funct == c_fn_multu) | (funct == c_fn_divu) |
                        (funct == c_fn_mfhi)  | (funct == c_fn_mflo);
    assign stall      = start & md_busy & w_md_funct & (aluop == c_aluop_funct);
    assign w_accept   = start & ~md_busy & (w_is_mul | w_is_div);
    assign w_last     = (r_cnt == c_last);

    // Shift-add: add multiplicand into the upper half when the LSB of the
    // multiplier is set, then shift the whole 2*WIDTH accumulator right.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

`ifdef DIV_EN
    logic             r_is_div;
    logic             r_div0;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;

    assign w_div_zero  = w_is_div & (op_b == '0);
    assign div0        = r_div0 & md_done;
    // Restoring step: remainder in acc_hi, dividend/quotient in acc_lo
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};

    always_comb begin
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_div_diff[WIDTH]) begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_step_hi = w_div_diff[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= w_is_div;
            r_div0   <= w_div_zero;
        end
    end
`else
    assign w_div_zero = 1'b0;
    assign div0       = 1'b0;
    assign w_step_hi  = w_mul_sum[WIDTH:1];
    assign w_step_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= op_a;
            r_opb    <= op_b;
            if (w_div_zero) begin
                r_hi <= op_a;
                r_lo <= '1;
            end
        end else if (md_busy) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (w_last) begin
                r_hi <= w_step_hi;
                r_lo <= w_step_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Self-checking bench for alu_ctrl_seq (WIDTH=32) against a
//               plain-arithmetic reference model. Honours DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int W = 32;
`ifdef DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    aluop;
    logic [5:0]    funct;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [2:0]    alu_ctrl;
    logic          illegal;
    logic          stall;
    logic [1:0]    mf_sel;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          md_busy;
    logic          md_done;
    logic          div0;

    int errors = 0;
    int checks = 0;

    alu_ctrl_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .aluop    (aluop),
        .funct    (funct),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal),
        .stall    (stall),
        .mf_sel   (mf_sel),
        .hi       (hi),
        .lo       (lo),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .div0     (div0)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the opcode tables: {alu_ctrl, illegal, mf_sel}
    function automatic logic [5:0] ref_decode(input logic [2:0] op, input logic [5:0] fn);
        logic [2:0] c;
        logic       il;
        logic [1:0] mf;
        c  = 3'b010;
        il = 1'b0;
        mf = 2'b00;
        case (op)
            3'd0: c = 3'b000;
            3'd1: c = 3'b001;
            3'd2: c = 3'b010;
            3'd3: c = 3'b110;
            3'd4: begin
                case (fn)
                    6'h20: c = 3'b010;
                    6'h22: c = 3'b110;
                    6'h24: c = 3'b000;
                    6'h25: c = 3'b001;
                    6'h2a: c = 3'b111;
                    6'h19: c = 3'b010;
                    6'h1b: il = !DIV_ON;
                    6'h10: mf = 2'b01;
                    6'h12: mf = 2'b10;
                    default: il = 1'b1;
                endcase
            end
            default: il = 1'b1;
        endcase
        return {c, il, mf};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        aluop = 3'd0;
        funct = 6'd0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hi, lo, md_busy, md_done, div0} !== '0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b div0=%b, required all zero",
                     hi, lo, md_busy, md_done, div0);
        end
        reset = 1'b0;
    endtask

    task automatic test_decode();
        logic [5:0] fns [13];
        logic [5:0] exp;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h19, 6'h1b, 6'h10, 6'h12,
                6'h00, 6'h3f, 6'($urandom), 6'($urandom)};
        @(negedge clk);
        start = 1'b0;
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 13; k++) begin
                aluop = 3'(op);
                funct = fns[k];
                #1;
                exp = ref_decode(aluop, funct);
                checks++;
                if ({alu_ctrl, illegal, mf_sel} !== exp || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL decode aluop=%b funct=%b: ctrl/ill/mf=%b stall=%b, required %b stall=0",
                             aluop, funct, {alu_ctrl, illegal, mf_sel}, stall, exp);
                end
            end
        end
    endtask

    // Issue one MULTU/DIVU and check busy/done profile and results per cycle.
    task automatic run_md(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [W-1:0]   eh, el;
        bit             ediv0;
        int             done_cyc;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (!is_div) begin
            eh = prod[2*W-1:W]; el = prod[W-1:0]; ediv0 = 1'b0; done_cyc = W + 1;
        end else if (b == '0) begin
            eh = a; el = '1; ediv0 = 1'b1; done_cyc = 1;
        end else begin
            eh = a % b; el = a / b; ediv0 = 1'b0; done_cyc = W + 1;
        end
        @(negedge clk);
        start = 1'b1;
        aluop = 3'b100;
        funct = is_div ? 6'h1b : 6'h19;
        op_a  = a;
        op_b  = b;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL md_issue_stall: stall=%b, required 0", stall);
        end
        for (int cyc = 1; cyc <= W + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            #1;
            checks++;
            if (md_busy !== (done_cyc == W + 1 && cyc <= W) || md_done !== (cyc == done_cyc)) begin
                errors++;
                $display("FAIL md_timing div=%0b cyc=%0d: busy=%b done=%b, required busy=%b done=%b",
                         is_div, cyc, md_busy, md_done, (done_cyc == W + 1 && cyc <= W), (cyc == done_cyc));
            end
            if (cyc == done_cyc) begin
                checks++;
                if (hi !== eh || lo !== el || div0 !== ediv0) begin
                    errors++;
                    $display("FAIL md_result div=%0b a=%h b=%h: hi=%h lo=%h div0=%b, required hi=%h lo=%h div0=%b",
                             is_div, a, b, hi, lo, div0, eh, el, ediv0);
                end
            end
        end
    endtask

    task automatic test_multiply();
        run_md(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(1'b0, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) run_md(1'b0, $urandom, $urandom);
    endtask

`ifdef DIV_EN
    task automatic test_divide();
        run_md(1'b1, 32'd100, 32'd7);
        run_md(1'b1, 32'd5, 32'd0);
        run_md(1'b1, 32'd3, 32'd9);
        for (int i = 0; i < 2; i++) run_md(1'b1, $urandom, 32'($urandom_range(1, 1000)));
        run_md(1'b1, $urandom, $urandom | 32'h1);
    endtask
`else
    task automatic test_config();
        logic [W-1:0] hi0, lo0;
        int           seen;
        hi0  = hi;
        lo0  = lo;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        aluop = 3'b100;
        funct = 6'h1b;
        op_a  = 32'd100;
        op_b  = 32'd7;
        #1;
        checks++;
        if (illegal !== 1'b1 || alu_ctrl !== 3'b010) begin
            errors++;
            $display("FAIL config_divu_decode: illegal=%b alu_ctrl=%b, required 1 and 010", illegal, alu_ctrl);
        end
        for (int cyc = 1; cyc <= W + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            #1;
            if (md_busy || md_done || div0) seen++;
        end
        checks++;
        if (seen != 0 || hi !== hi0 || lo !== lo0) begin
            errors++;
            $display("FAIL config_divu_inert: active cycles=%0d hi=%h lo=%h, required 0 cycles hi=%h lo=%h",
                     seen, hi, lo, hi0, lo0);
        end
    endtask
`endif

    task automatic test_stall();
        logic [W-1:0]   a, b;
        logic [2*W-1:0] prod;
        a    = $urandom;
        b    = $urandom;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        @(negedge clk);
        start = 1'b1;
        aluop = 3'b100;
        funct = 6'h19;
        op_a  = a;
        op_b  = b;
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 10) begin
                start = 1'b1;
                funct = 6'h20;
                #1;
                checks++;
                if (stall !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_add cyc=10: stall=%b, required 0", stall);
                end
                funct = 6'h10;
            end
            if (cyc >= 10) begin
                #1;
                checks++;
                if (stall !== (cyc <= W)) begin
                    errors++;
                    $display("FAIL stall_mfhi cyc=%0d: stall=%b, required %b", cyc, stall, (cyc <= W));
                end
            end
        end
        checks++;
        if (mf_sel !== 2'b01 || hi !== prod[2*W-1:W]) begin
            errors++;
            $display("FAIL stall_mfhi_read: mf_sel=%b hi=%h, required 01 hi=%h", mf_sel, hi, prod[2*W-1:W]);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a1, b1, a2, b2;
        logic [2*W-1:0] p1, p2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        p1 = {{W{1'b0}}, a1} * {{W{1'b0}}, b1};
        p2 = {{W{1'b0}}, a2} * {{W{1'b0}}, b2};
        @(negedge clk);
        start = 1'b1; aluop = 3'b100; funct = 6'h19; op_a = a1; op_b = b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);
        #1;
        checks++;
        if (md_done !== 1'b1 || {hi, lo} !== p1) begin
            errors++;
            $display("FAIL b2b_first: done=%b hi:lo=%h, required 1 %h", md_done, {hi, lo}, p1);
        end
        start = 1'b1; op_a = a2; op_b = b2;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_stall: stall=%b, required 0", stall);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b1 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", md_busy, md_done);
        end
        repeat (W) @(negedge clk);
        #1;
        checks++;
        if (md_done !== 1'b1 || {hi, lo} !== p2) begin
            errors++;
            $display("FAIL b2b_second: done=%b hi:lo=%h, required 1 %h", md_done, {hi, lo}, p2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", md_done, md_busy);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        aluop = 3'b100;
        funct = DIV_ON ? 6'h1b : 6'h19;
        op_a  = 32'd100;
        op_b  = 32'd7;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({hi, lo, md_busy, md_done, div0} !== '0) begin
            errors++;
            $display("FAIL reset_abort_async: hi=%h lo=%h busy=%b done=%b div0=%b, required all zero",
                     hi, lo, md_busy, md_done, div0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < W + 8; cyc++) begin
            @(negedge clk);
            #1;
            if (md_done || md_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort_quiet: active cycles=%0d, required 0", seen);
        end
        run_md(1'b0, 32'd3, 32'd4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_multiply();
`ifdef DIV_EN
        test_divide();
`else
        test_config();
`endif
        test_stall();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
